// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage core's inter-stage pipeline registers.
// Holds the NOP encoding, the default reset PC and the payload width used at
// each stage boundary so the pipeline, hazard and forwarding units agree.
package pipe_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  // Payload widths per stage boundary (control + operand bits carried forward)
  localparam int unsigned FD_W = 8;
  localparam int unsigned DE_W = 96;
  localparam int unsigned EM_W = 80;
  localparam int unsigned MW_W = 48;

  // Fixed header that every stage register carries alongside its payload
  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               bd;
  } stage_hdr_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (sync, active-high), clr (sync clear, beats inc),
//        inc (count up one), count (registered value, stops at all-ones).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up until all-ones, then hold
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: PC, instruction, branch-delay
// flag and a generic payload, with valid bit, flush-to-bubble, optional
// PC-preserving flush and a saturating count of cycles a valid entry is held.
// Ports: clk, reset (sync, active-high), en (load; 0 = hold), flush (bubble),
//        in_valid/in_pc/in_instr/in_bd/in_payload (upstream stage),
//        out_valid/out_pc/out_instr/out_bd/out_payload (registered contents),
//        stall_cycles (consecutive hold cycles of a valid entry).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     DATA_W           = 64,
  parameter int unsigned     CNT_W            = 8,
  parameter bit              KEEP_PC_ON_FLUSH = 1'b0,
  parameter logic [PC_W-1:0] RESET_PC         = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_bd,
  input  logic [DATA_W-1:0]  in_payload,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_bd,
  output logic [DATA_W-1:0]  out_payload,
  output logic [CNT_W-1:0]   stall_cycles
);

  stage_hdr_t          hdr_q;
  logic [DATA_W-1:0]   payload_q;

  // Stage contents: reset > flush > hold > load
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q.valid <= 1'b0;
      hdr_q.pc    <= RESET_PC;
      hdr_q.instr <= NOP_INSTR;
      hdr_q.bd    <= 1'b0;
      payload_q   <= '0;
    end else if (flush) begin
      hdr_q.valid <= 1'b0;
      hdr_q.instr <= NOP_INSTR;
      hdr_q.bd    <= 1'b0;
      payload_q   <= '0;
      // EPC capture needs the faulting PC to survive the flush
      if (!KEEP_PC_ON_FLUSH) begin
        hdr_q.pc <= RESET_PC;
      end
    end else if (en) begin
      hdr_q.valid <= in_valid;
      hdr_q.pc    <= in_pc;
      hdr_q.bd    <= in_bd;
      // Bubbles must not carry stale control bits downstream
      hdr_q.instr <= in_valid ? in_instr : NOP_INSTR;
      payload_q   <= in_valid ? in_payload : '0;
    end
  end

  // Counts only while a valid entry is held; any load or flush restarts it
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (flush | en),
    .inc   (~en & hdr_q.valid),
    .count (stall_cycles)
  );

  assign out_valid   = hdr_q.valid;
  assign out_pc      = hdr_q.pc;
  assign out_instr   = hdr_q.instr;
  assign out_bd      = hdr_q.bd;
  assign out_payload = payload_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed test of pipe_stage_reg. Two instances share the stimulus:
//   u_dut0: DATA_W=64, CNT_W=8, flush loads RESET_PC=32'hBFC0_0000
//   u_dut1: DATA_W=16, CNT_W=3, flush keeps PC, RESET_PC=32'h0000_0400
module tb_pipe_stage_reg;

  localparam logic [31:0] RPC0 = 32'hBFC0_0000;
  localparam logic [31:0] RPC1 = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset, en, flush, in_valid, in_bd;
  logic [31:0] in_pc, in_instr;
  logic [63:0] in_payload;

  logic        v0, v1, bd0, bd1;
  logic [31:0] pc0, pc1, ins0, ins1;
  logic [63:0] pl0;
  logic [15:0] pl1;
  logic [7:0]  sc0;
  logic [2:0]  sc1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(64), .CNT_W(8), .KEEP_PC_ON_FLUSH(1'b0), .RESET_PC(RPC0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .in_payload(in_payload),
    .out_valid(v0), .out_pc(pc0), .out_instr(ins0), .out_bd(bd0),
    .out_payload(pl0), .stall_cycles(sc0)
  );

  pipe_stage_reg #(
    .DATA_W(16), .CNT_W(3), .KEEP_PC_ON_FLUSH(1'b1), .RESET_PC(RPC1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .in_payload(in_payload[15:0]),
    .out_valid(v1), .out_pc(pc1), .out_instr(ins1), .out_bd(bd1),
    .out_payload(pl1), .stall_cycles(sc1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic bd, input logic [63:0] pl);
    reset = r; en = e; flush = f; in_valid = v;
    in_pc = pc; in_instr = ins; in_bd = bd; in_payload = pl;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_v0"},   64'(v0), 64'd0);
    check_eq({tag, "_pc0"},  64'(pc0), 64'(RPC0));
    check_eq({tag, "_ins0"}, 64'(ins0), 64'd0);
    check_eq({tag, "_bd0"},  64'(bd0), 64'd0);
    check_eq({tag, "_pl0"},  pl0, 64'd0);
    check_eq({tag, "_sc0"},  64'(sc0), 64'd0);
    check_eq({tag, "_v1"},   64'(v1), 64'd0);
    check_eq({tag, "_pc1"},  64'(pc1), 64'(RPC1));
    check_eq({tag, "_ins1"}, 64'(ins1), 64'd0);
    check_eq({tag, "_pl1"},  64'(pl1), 64'd0);
    check_eq({tag, "_sc1"},  64'(sc1), 64'd0);
  endtask

  initial begin
    // Reset for two cycles, with live inputs that must be ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check_reset_vals("rst1");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 1'b1, 64'h55);
    tick();
    check_reset_vals("rst2");

    // First load after release
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 32'h2408_0005, 1'b1, 64'hDEAD_BEEF_0123_4567);
    tick();
    check_eq("ld_v0",   64'(v0), 64'd1);
    check_eq("ld_pc0",  64'(pc0), 64'h3000);
    check_eq("ld_ins0", 64'(ins0), 64'h2408_0005);
    check_eq("ld_bd0",  64'(bd0), 64'd1);
    check_eq("ld_pl0",  pl0, 64'hDEAD_BEEF_0123_4567);
    check_eq("ld_pl1",  64'(pl1), 64'h4567);
    check_eq("ld_sc0",  64'(sc0), 64'd0);

    // Hold 5 cycles with changing inputs: counter 1..5, contents unchanged
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000 + 32'(i), 32'hAAAA_0000, 1'b0, 64'h1);
      tick();
      check_eq($sformatf("hold_sc0_%0d", i), 64'(sc0), 64'(i + 1));
      check_eq($sformatf("hold_sc1_%0d", i), 64'(sc1), 64'(i + 1));
    end
    check_eq("hold_pc0",  64'(pc0), 64'h3000);
    check_eq("hold_ins1", 64'(ins1), 64'h2408_0005);
    check_eq("hold_v1",   64'(v1), 64'd1);

    // Next load clears the counter
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h3004, 32'h0000_000C, 1'b0, 64'h7);
    tick();
    check_eq("reld_sc0", 64'(sc0), 64'd0);
    check_eq("reld_sc1", 64'(sc1), 64'd0);
    check_eq("reld_pc1", 64'(pc1), 64'h3004);

    // Hold 10 cycles: 3-bit counter saturates at 7, 8-bit keeps counting
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0);
      tick();
      check_eq($sformatf("sat_sc1_%0d", i), 64'(sc1), 64'((i + 1 > 7) ? 7 : i + 1));
    end
    check_eq("sat_sc0", 64'(sc0), 64'd10);

    // Load entry at 3010, stall, then flush while stalled
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h3010, 32'h8C09_0004, 1'b1, 64'hFFFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3014, 32'h0, 1'b0, 64'h0);
    tick();
    tick();
    check_eq("pre_fl_sc1", 64'(sc1), 64'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3018, 32'h1111_1111, 1'b1, 64'hFFFF);
    tick();
    check_eq("fl_v1",   64'(v1), 64'd0);
    check_eq("fl_ins1", 64'(ins1), 64'd0);
    check_eq("fl_pc1",  64'(pc1), 64'h3010);
    check_eq("fl_bd1",  64'(bd1), 64'd0);
    check_eq("fl_pl1",  64'(pl1), 64'd0);
    check_eq("fl_sc1",  64'(sc1), 64'd0);
    check_eq("fl_v0",   64'(v0), 64'd0);
    check_eq("fl_pc0",  64'(pc0), 64'(RPC0));
    check_eq("fl_sc0",  64'(sc0), 64'd0);

    // Bubble load: instr/payload forced to zero, pc/bd load normally
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3020, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check_eq("bub_v0",   64'(v0), 64'd0);
    check_eq("bub_ins0", 64'(ins0), 64'd0);
    check_eq("bub_pl0",  pl0, 64'd0);
    check_eq("bub_pl1",  64'(pl1), 64'd0);
    check_eq("bub_pc0",  64'(pc0), 64'h3020);
    check_eq("bub_bd0",  64'(bd0), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3024, 32'h0, 1'b0, 64'h0);
    tick();
    tick();
    check_eq("bub_hold_sc0", 64'(sc0), 64'd0);
    check_eq("bub_hold_sc1", 64'(sc1), 64'd0);

    // Priority: reset with flush and en while a valid entry is stalled
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h3030, 32'h2402_000A, 1'b0, 64'h99);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check_eq("pri_pre_sc0", 64'(sc0), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h3040, 32'h2403_000B, 1'b1, 64'h77);
    tick();
    check_reset_vals("pri");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
